// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: receive FSM states, bus-width modes and the MISO line index.
package qspi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMMY = 2'd1,
    SHIFT = 2'd2
  } rx_state_t;

  localparam logic QSPI_SINGLE   = 1'b0;
  localparam logic QSPI_QUAD     = 1'b1;
  localparam int   QSPI_MISO_IDX = 1;

  // Next shift-register value: one bit from MISO in single mode, a nibble in quad mode.
  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic quad,
                                          input logic [3:0] io);
    return (quad == QSPI_QUAD) ? {sr[3:0], io} : {sr[6:0], io[QSPI_MISO_IDX]};
  endfunction

endpackage

// File: rtl/qspi_rx_shift_reg.sv
// QSPI receive deserializer: skips dummy strobes, assembles MSB-first bytes, and
// hands them to the RX FIFO through a one-entry valid/ready register.
module qspi_rx_shift_reg
  import qspi_pkg::*;
#(
  parameter int DUMMY_W = 4,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_start,
  input  logic [LEN_W-1:0]   rx_len,
  input  logic               quad_mode,
  input  logic [DUMMY_W-1:0] dummy_cycles,
  input  logic               abort,
  input  logic               sample_en,
  input  logic [3:0]         io_in,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  rx_state_t          state, state_nxt;
  logic               quad;
  logic [DUMMY_W-1:0] dummy_cnt;
  logic [2:0]         bit_cnt;
  logic [LEN_W-1:0]   byte_cnt;
  logic [7:0]         sr;
  logic [7:0]         sr_nxt;
  logic               start_ok;
  logic               shift_stb;
  logic               byte_done;
  logic               last_byte;

  assign start_ok  = rx_start && (state == IDLE) && !abort;
  assign shift_stb = sample_en && (state == SHIFT) && !abort;
  assign sr_nxt    = shift_in(sr, quad, io_in);
  assign byte_done = shift_stb && (bit_cnt == ((quad == QSPI_QUAD) ? 3'd1 : 3'd7));
  // byte_cnt holds bytes remaining minus one, so 0 marks the final byte.
  assign last_byte = byte_done && (byte_cnt == '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rx_start) state_nxt = (dummy_cycles != '0) ? DUMMY : SHIFT;
        DUMMY:   if (sample_en && (dummy_cnt == DUMMY_W'(1))) state_nxt = SHIFT;
        SHIFT:   if (last_byte) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quad      <= QSPI_SINGLE;
      dummy_cnt <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      sr        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= last_byte;

      if (abort) begin
        dummy_cnt <= '0;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
      end else if (start_ok) begin
        quad      <= quad_mode;
        dummy_cnt <= dummy_cycles;
        byte_cnt  <= rx_len;
        bit_cnt   <= '0;
        overflow  <= 1'b0;
      end else begin
        if ((state == DUMMY) && sample_en) dummy_cnt <= dummy_cnt - DUMMY_W'(1);
        if (shift_stb) begin
          sr      <= sr_nxt;
          bit_cnt <= byte_done ? 3'd0 : bit_cnt + 3'd1;
          if (byte_done && !last_byte) byte_cnt <= byte_cnt - LEN_W'(1);
        end
      end

      // Output register: a new byte may replace one being consumed this cycle.
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= sr_nxt;
          rx_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qspi_rx_shift_reg.sv
// Directed bench for qspi_rx_shift_reg with a byte/done scoreboard monitor.
module tb_qspi_rx_shift_reg;

  localparam int DUMMY_W = 4;
  localparam int LEN_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx_start;
  logic [LEN_W-1:0]   rx_len;
  logic               quad_mode;
  logic [DUMMY_W-1:0] dummy_cycles;
  logic               abort;
  logic               sample_en;
  logic [3:0]         io_in;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               busy;
  logic               done;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  logic [7:0] exp_done[$];

  qspi_rx_shift_reg #(.DUMMY_W(DUMMY_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_start(rx_start), .rx_len(rx_len),
    .quad_mode(quad_mode), .dummy_cycles(dummy_cycles), .abort(abort),
    .sample_en(sample_en), .io_in(io_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bytes on each handshake and expected data on each done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_bytes.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL byte: got 0x%0h expected 0x%0h", rx_data, e);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done with 0x%0h expected no done", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_done.pop_front();
          if (rx_data !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_data: got 0x%0h busy %0b expected 0x%0h busy 0", rx_data, busy, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [LEN_W-1:0] len, input logic q, input logic [DUMMY_W-1:0] dmy);
    rx_start = 1'b1; rx_len = len; quad_mode = q; dummy_cycles = dmy;
    step();
    rx_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sample_en = 1'b1; io_in = {2'b00, b, 1'b0};
    step();
    sample_en = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    sample_en = 1'b1; io_in = n;
    step();
    sample_en = 1'b0;
  endtask

  task automatic send_byte_single(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; rx_start = 1'b0; rx_len = '0; quad_mode = 1'b0; dummy_cycles = '0;
    abort = 1'b0; sample_en = 1'b0; io_in = 4'h0; rx_ready = 1'b1;
    step(); step();
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step();

    // 1: single mode 0xA5
    exp_bytes.push_back(8'hA5); exp_done.push_back(8'hA5);
    start(8'd0, 1'b0, 4'd0);
    chk("t1_busy", busy, 1);
    pat = 8'b1010_0101;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    chk("t1_valid_before", rx_valid, 0);
    send_bit(pat[0]);
    chk("t1_valid", rx_valid, 1);
    chk("t1_done", done, 1);
    chk("t1_data", rx_data, 8'hA5);
    step(); step();
    chk("t1_done_once", done, 0);

    // 2: quad, 3 bytes, 4 dummy strobes
    exp_bytes.push_back(8'hDE); exp_bytes.push_back(8'hAD); exp_bytes.push_back(8'hBE);
    exp_done.push_back(8'hBE);
    start(8'd2, 1'b1, 4'd4);
    for (int i = 0; i < 4; i++) send_nib(4'hF);
    chk("t2_no_valid_dummy", rx_valid, 0);
    send_nib(4'hD); send_nib(4'hE);
    chk("t2_busy_mid", busy, 1);
    send_nib(4'hA); send_nib(4'hD);
    send_nib(4'hB); send_nib(4'hE);
    chk("t2_last", rx_data, 8'hBE);
    step(); step();

    // 3: overflow
    rx_ready = 1'b0;
    exp_done.push_back(8'h12);
    start(8'd1, 1'b1, 4'd0);
    send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h4);
    chk("t3_data_kept", rx_data, 8'h12);
    chk("t3_overflow", overflow, 1);
    step();
    chk("t3_overflow_sticky", overflow, 1);
    exp_bytes.push_back(8'h12);
    rx_ready = 1'b1;
    step();
    chk("t3_drained", rx_valid, 0);
    exp_bytes.push_back(8'h56); exp_done.push_back(8'h56);
    start(8'd0, 1'b1, 4'd0);
    chk("t3_overflow_clr", overflow, 0);
    send_nib(4'h5); send_nib(4'h6);
    step(); step();

    // 4: completion coincides with consume
    rx_ready = 1'b0;
    exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h22); exp_done.push_back(8'h22);
    start(8'd1, 1'b1, 4'd0);
    send_nib(4'h1); send_nib(4'h1);
    send_nib(4'h2);
    rx_ready = 1'b1;
    send_nib(4'h2);
    chk("t4_data", rx_data, 8'h22);
    chk("t4_valid", rx_valid, 1);
    chk("t4_no_overflow", overflow, 0);
    step(); step();

    // 5: abort mid-byte, then 0x3C
    start(8'd0, 1'b0, 4'd0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    abort = 1'b1; sample_en = 1'b1;
    step();
    abort = 1'b0; sample_en = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", rx_valid, 0);
    chk("t5_done", done, 0);
    step(); step();
    exp_bytes.push_back(8'h3C); exp_done.push_back(8'h3C);
    start(8'd0, 1'b0, 4'd0);
    send_byte_single(8'h3C);
    chk("t5_data", rx_data, 8'h3C);
    step(); step();

    // 6a: reset mid-transfer with a pending byte and overflow set
    rx_ready = 1'b0;
    start(8'd3, 1'b1, 4'd0);
    send_nib(4'hA); send_nib(4'hB); send_nib(4'hC); send_nib(4'hD); send_nib(4'hE);
    chk("t6_pre_overflow", overflow, 1);
    rst_n = 1'b0;
    step();
    chk("t6_rx_data", rx_data, 8'h00);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_overflow", overflow, 0);
    rst_n = 1'b1; rx_ready = 1'b1;
    step();

    // 6b: rx_start while busy is ignored
    exp_bytes.push_back(8'hC3); exp_done.push_back(8'hC3);
    start(8'd0, 1'b0, 4'd0);
    pat = 8'hC3;
    for (int i = 7; i >= 4; i--) send_bit(pat[i]);
    rx_start = 1'b1; rx_len = 8'd5; quad_mode = 1'b1; dummy_cycles = 4'd3;
    send_bit(pat[3]);
    rx_start = 1'b0;
    for (int i = 2; i >= 0; i--) send_bit(pat[i]);
    chk("t6_ign_data", rx_data, 8'hC3);
    chk("t6_ign_done", done, 1);
    step();
    chk("t6_ign_idle", busy, 0);
    step(); step();

    chk("sb_bytes_left", exp_bytes.size(), 0);
    chk("sb_done_left", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
